// File: rtl/keylock_pkg.sv
// Shared types and constants for the keypad lock sequencer.
package keylock_pkg;

  localparam int unsigned CODE_DIGITS = 6;
  localparam int unsigned CODE_W      = 4 * CODE_DIGITS;
  localparam int unsigned COUNT_W     = 4;

  localparam logic [3:0] KEY_CLEAR   = 4'd10;
  localparam logic       PAT_SUCCESS = 1'b0;
  localparam logic       PAT_ERROR   = 1'b1;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_UNLOCKED,
    ST_ENROLL_NEW,
    ST_ENROLL_CONFIRM,
    ST_LOCKOUT
  } state_e;

  // Keys 0-9 are digits; 10 is clear; 11-15 carry no meaning.
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keylock_sequencer_if.sv
// Keypad event, pattern-generator handshake and status bundle.
interface keylock_sequencer_if;
  import keylock_pkg::*;

  logic               key_valid;
  logic [3:0]         key;
  logic               pat_done;
  logic               pat_start;
  logic               pat_sel;
  logic               unlocked;
  logic               enrolling;
  logic               confirming;
  logic               lockout;
  logic [COUNT_W-1:0] digit_count;
  logic [1:0]         fail_count;

  // Keypad front end / pattern generator side.
  modport master (
    output key_valid, key, pat_done,
    input  pat_start, pat_sel, unlocked, enrolling, confirming, lockout,
           digit_count, fail_count
  );

  // Sequencer side.
  modport slave (
    input  key_valid, key, pat_done,
    output pat_start, pat_sel, unlocked, enrolling, confirming, lockout,
           digit_count, fail_count
  );
endinterface

// File: rtl/keylock_sequencer_code_buffer.sv
// Digit shift register with count, clear and code-completion detect.
module keylock_sequencer_code_buffer
  import keylock_pkg::*;
(
  input  logic               hwclk,
  input  logic               reset,
  input  logic               digit_en,
  input  logic               clear_en,
  input  logic [3:0]         key,
  output code_t              code_c,
  output logic               complete_c,
  output logic [COUNT_W-1:0] digit_count
);

  logic [CODE_W-5:0]  digits_q, digits_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // The code under evaluation is the buffered digits with the new key appended.
  assign code_c      = {digits_q, key};
  assign complete_c  = digit_en && (count_q == COUNT_W'(CODE_DIGITS - 1));
  assign digit_count = count_q;

  // Shift in digits; empty on clear or when a code completes.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (clear_en || complete_c) begin
      digits_d = '0;
      count_d  = '0;
    end else if (digit_en) begin
      digits_d = code_c[CODE_W-5:0];
      count_d  = count_q + COUNT_W'(1);
    end
  end

  // Buffer registers.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keylock_sequencer.sv
// Keypad lock sequencer: code entry, compare, enrollment, lockout and timeout.
module keylock_sequencer
  import keylock_pkg::*;
#(
  parameter code_t       MASTER_CODE    = 24'h555116,
  parameter code_t       USER_INIT      = 24'h666666,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 120000000,
  parameter int unsigned TIMEOUT_CYCLES = 60000000
) (
  input  logic                hwclk,
  input  logic                reset,
  keylock_sequencer_if.slave  bus
);

  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [1:0]         fail_q, fail_d;
  code_t              user_q, user_d;
  code_t              cand_q, cand_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic               pat_start_q, pat_start_d;
  logic               pat_sel_q, pat_sel_d;
  logic               unlocked_q, unlocked_d;
  logic               enrolling_q, enrolling_d;
  logic               confirming_q, confirming_d;
  logic               lockout_q, lockout_d;

  logic               key_ok_c;
  logic               digit_en_c;
  logic               clear_key_c;
  logic               accepted_c;
  logic               timeout_c;
  logic               lock_expire_c;
  logic               complete_c;
  code_t              code_c;
  logic [COUNT_W-1:0] count_w;
  logic [1:0]         fail_inc_c;

  // Keys are dropped while a pattern is running, on its done pulse, and in lockout.
  assign key_ok_c      = bus.key_valid && !busy_q && !bus.pat_done && (state_q != ST_LOCKOUT);
  assign digit_en_c    = key_ok_c && is_digit(bus.key);
  assign clear_key_c   = key_ok_c && (bus.key == KEY_CLEAR);
  assign accepted_c    = digit_en_c || clear_key_c;
  assign timeout_c     = (count_w != '0) && !accepted_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign lock_expire_c = (state_q == ST_LOCKOUT) && (lock_q == LOCK_W'(LOCKOUT_CYCLES - 1));
  assign fail_inc_c    = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

  keylock_sequencer_code_buffer u_code_buffer (
    .hwclk       (hwclk),
    .reset       (reset),
    .digit_en    (digit_en_c),
    .clear_en    (clear_key_c || timeout_c),
    .key         (bus.key),
    .code_c      (code_c),
    .complete_c  (complete_c),
    .digit_count (count_w)
  );

  // Idle-gap and lockout timers.
  always_comb begin
    tmo_d  = tmo_q;
    lock_d = '0;
    if (accepted_c || (count_w == '0)) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if (state_q == ST_LOCKOUT) begin
      lock_d = lock_q + LOCK_W'(1);
    end
  end

  // Next state, code compare, pattern requests and status decode.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    fail_d      = fail_q;
    user_d      = user_q;
    cand_d      = cand_q;
    pat_start_d = 1'b0;
    pat_sel_d   = pat_sel_q;

    if (bus.pat_done) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_LOCKED: begin
        if (complete_c) begin
          pat_start_d = 1'b1;
          if (code_c == user_q) begin
            state_d   = ST_UNLOCKED;
            fail_d    = '0;
            pat_sel_d = PAT_SUCCESS;
          end else if (code_c == MASTER_CODE) begin
            state_d   = ST_ENROLL_NEW;
            pat_sel_d = PAT_SUCCESS;
          end else begin
            fail_d    = fail_inc_c;
            pat_sel_d = PAT_ERROR;
            if (32'(fail_inc_c) == MAX_FAILS) begin
              state_d = ST_LOCKOUT;
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (complete_c) begin
          pat_start_d = 1'b1;
          if (code_c == user_q) begin
            state_d   = ST_LOCKED;
            pat_sel_d = PAT_SUCCESS;
          end else begin
            pat_sel_d = PAT_ERROR;
          end
        end
      end

      ST_ENROLL_NEW: begin
        if (complete_c) begin
          if (code_c == MASTER_CODE) begin
            state_d     = ST_LOCKED;
            pat_start_d = 1'b1;
            pat_sel_d   = PAT_ERROR;
          end else begin
            cand_d  = code_c;
            state_d = ST_ENROLL_CONFIRM;
          end
        end else if (timeout_c) begin
          state_d     = ST_LOCKED;
          pat_start_d = 1'b1;
          pat_sel_d   = PAT_ERROR;
        end
      end

      ST_ENROLL_CONFIRM: begin
        if (complete_c) begin
          state_d     = ST_LOCKED;
          pat_start_d = 1'b1;
          if (code_c == cand_q) begin
            user_d    = cand_q;
            pat_sel_d = PAT_SUCCESS;
          end else begin
            pat_sel_d = PAT_ERROR;
          end
        end else if (timeout_c) begin
          state_d     = ST_LOCKED;
          pat_start_d = 1'b1;
          pat_sel_d   = PAT_ERROR;
        end
      end

      ST_LOCKOUT: begin
        if (lock_expire_c) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase

    if (pat_start_d) begin
      busy_d = 1'b1;
    end

    unlocked_d   = (state_d == ST_UNLOCKED);
    enrolling_d  = (state_d == ST_ENROLL_NEW) || (state_d == ST_ENROLL_CONFIRM);
    confirming_d = (state_d == ST_ENROLL_CONFIRM);
    lockout_d    = (state_d == ST_LOCKOUT);
  end

  // State, code storage, timers and registered outputs.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOCKED;
      busy_q       <= 1'b0;
      fail_q       <= '0;
      user_q       <= USER_INIT;
      cand_q       <= '0;
      tmo_q        <= '0;
      lock_q       <= '0;
      pat_start_q  <= 1'b0;
      pat_sel_q    <= 1'b0;
      unlocked_q   <= 1'b0;
      enrolling_q  <= 1'b0;
      confirming_q <= 1'b0;
      lockout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      fail_q       <= fail_d;
      user_q       <= user_d;
      cand_q       <= cand_d;
      tmo_q        <= tmo_d;
      lock_q       <= lock_d;
      pat_start_q  <= pat_start_d;
      pat_sel_q    <= pat_sel_d;
      unlocked_q   <= unlocked_d;
      enrolling_q  <= enrolling_d;
      confirming_q <= confirming_d;
      lockout_q    <= lockout_d;
    end
  end

  assign bus.pat_start   = pat_start_q;
  assign bus.pat_sel     = pat_sel_q;
  assign bus.unlocked    = unlocked_q;
  assign bus.enrolling   = enrolling_q;
  assign bus.confirming  = confirming_q;
  assign bus.lockout     = lockout_q;
  assign bus.digit_count = count_w;
  assign bus.fail_count  = fail_q;

endmodule
